// File: rtl/sync_frame_serializer.sv
// Serial frame transmitter: sync preamble, then the payload MSB-first, optionally followed by an even-parity bit.
// Optional feature macro: SYNC_FRAME_SERIALIZER_PARITY_EN (adds the PARITY state and the par register).
module sync_frame_serializer #(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = 4,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b0110,
  parameter logic              IDLE_BIT     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              out,
  output logic              busy,
  output logic              done
);

  localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

`ifdef SYNC_FRAME_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic              accept;

  // The last bit of the frame is the one cycle in which a new word may be taken without a gap.
`ifdef SYNC_FRAME_SERIALIZER_PARITY_EN
  assign last = (state == PARITY);
`else
  assign last = (state == DATA) && (cnt == '0);
`endif

  assign done       = last;
  assign busy       = (state != IDLE);
  assign data_ready = (state == IDLE) || last;
  assign accept     = data_valid && data_ready;

  always_comb begin
    out = IDLE_BIT;
    case (state)
      SYNC:    out = SYNC_PATTERN[cnt];
      DATA:    out = shreg[DATA_W-1];
`ifdef SYNC_FRAME_SERIALIZER_PARITY_EN
      PARITY:  out = par;
`endif
      default: out = IDLE_BIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef SYNC_FRAME_SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (state)
        SYNC: begin
          if (cnt == '0) begin
            state <= DATA;
            cnt   <= DATA_LAST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          shreg <= shreg << 1;
          if (cnt == '0) begin
`ifdef SYNC_FRAME_SERIALIZER_PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef SYNC_FRAME_SERIALIZER_PARITY_EN
        PARITY:  state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
      // Accept is only possible in IDLE or the last bit, so it overrides the end-of-frame move to IDLE.
      if (accept) begin
        state <= SYNC;
        shreg <= data_in;
        cnt   <= SYNC_LAST;
`ifdef SYNC_FRAME_SERIALIZER_PARITY_EN
        par   <= ^data_in;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sync_frame_serializer.sv
// Directed bench for sync_frame_serializer; expected frames are hand-written for both macro settings.
module tb_sync_frame_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       out;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

`ifdef SYNC_FRAME_SERIALIZER_PARITY_EN
  localparam int         FL   = 13;
  localparam logic [15:0] F_A5 = {3'b0, 12'b0110_1010_0101, 1'b0};
  localparam logic [15:0] F_FF = {3'b0, 12'b0110_1111_1111, 1'b0};
  localparam logic [15:0] F_00 = {3'b0, 12'b0110_0000_0000, 1'b0};
  localparam logic [15:0] F_3C = {3'b0, 12'b0110_0011_1100, 1'b0};
  localparam logic [15:0] F_5A = {3'b0, 12'b0110_0101_1010, 1'b0};
  localparam logic [15:0] F_01 = {3'b0, 12'b0110_0000_0001, 1'b1};
`else
  localparam int         FL   = 12;
  localparam logic [15:0] F_A5 = {4'b0, 12'b0110_1010_0101};
  localparam logic [15:0] F_FF = {4'b0, 12'b0110_1111_1111};
  localparam logic [15:0] F_00 = {4'b0, 12'b0110_0000_0000};
  localparam logic [15:0] F_3C = {4'b0, 12'b0110_0011_1100};
  localparam logic [15:0] F_5A = {4'b0, 12'b0110_0101_1010};
  localparam logic [15:0] F_01 = {4'b0, 12'b0110_0000_0001};
`endif

  always #5 clk = ~clk;

  sync_frame_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .out        (out),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: drop valid after the accept; 1: toggle valid with 8'h3C, high on the done cycle;
  // 2: keep valid high and switch data_in to 8'h00 after the accept.
  task automatic run_bits(input string tag, input logic [15:0] bits, input int len,
                          input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_out%0d", tag, i),  32'(out),        32'(bits[len-1-i]));
      check($sformatf("%s_done%0d", tag, i), 32'(done),       32'(i == len-1));
      check($sformatf("%s_rdy%0d", tag, i),  32'(data_ready), 32'(i == len-1));
      check($sformatf("%s_busy%0d", tag, i), 32'(busy),       32'd1);
      case (mode)
        0: if (i == 0) data_valid = 1'b0;
        1: begin
          data_valid = (((len - 1 - i) % 2) == 0);
          data_in    = 8'h3C;
        end
        2: if (i == 0) data_in = 8'h00;
        default: ;
      endcase
    end
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_out"},  32'(out),        32'd1);
    check({tag, "_busy"}, 32'(busy),       32'd0);
    check({tag, "_rdy"},  32'(data_ready), 32'd1);
    check({tag, "_done"}, 32'(done),       32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    #12;
    check("rst_out",  32'(out),        32'd1);
    check("rst_rdy",  32'(data_ready), 32'd1);
    check("rst_busy", 32'(busy),       32'd0);
    check("rst_done", 32'(done),       32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) idle_check($sformatf("idle%0d", k));

    // Single frame
    data_valid = 1'b1;
    data_in    = 8'hA5;
    run_bits("t2", F_A5, FL, FL, 0);
    idle_check("t2_end");

    // Back-to-back frames with valid held high
    data_valid = 1'b1;
    data_in    = 8'hFF;
    run_bits("t3a", F_FF, FL, FL, 2);
    run_bits("t3b", F_00, FL, FL, 0);
    idle_check("t3_end");

    // Valid toggling during a frame is ignored until the done edge
    data_valid = 1'b1;
    data_in    = 8'hA5;
    run_bits("t4a", F_A5, FL, FL, 1);
    run_bits("t4b", F_3C, FL, FL, 0);
    idle_check("t4_end");

    // Asynchronous reset during the 6th bit
    data_valid = 1'b1;
    data_in    = 8'hA5;
    run_bits("t5a", F_A5, FL, 6, 0);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_out",  32'(out),        32'd1);
    check("t5_rst_busy", 32'(busy),       32'd0);
    check("t5_rst_rdy",  32'(data_ready), 32'd1);
    check("t5_rst_done", 32'(done),       32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_check("t5_idle");
    data_valid = 1'b1;
    data_in    = 8'h5A;
    run_bits("t5b", F_5A, FL, FL, 0);
    idle_check("t5_end");

    // Frame whose parity bit is 1 when parity is enabled
    data_valid = 1'b1;
    data_in    = 8'h01;
    run_bits("t6", F_01, FL, FL, 0);
    idle_check("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
